i281_run_sequencer: RTL

Synthesizable run/reset sequencer for the i281 multicycle CPU. It generalises the fixed "hold reset, release, assert run, stop after N ns" bench stimulus into a parametrised on-chip controller. It holds `cpu_reset` for a programmable number of cycles, then drives `cpu_run` continuously or one pulse per `step`. It stops on CPU halt, a data-memory watch match, a cycle budget or abort, and reports why. It sits between the board/bench controls and `i281_toplevel`'s `run`/`reset` inputs, and snoops the `datamem0..N` outputs.

---
 rtl/i281_run_seq_pkg.sv | 18 +
 rtl/i281_mem_watch.sv | 24 ++
 rtl/i281_run_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/i281_run_seq_pkg.sv
// Shared definitions for the i281 run/reset sequencer: FSM state type and
// stop-reason codes reported on stop_code.
package i281_run_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  localparam logic [1:0] STOP_ABORT   = 2'b00;
  localparam logic [1:0] STOP_HALT    = 2'b01;
  localparam logic [1:0] STOP_WATCH   = 2'b10;
  localparam logic [1:0] STOP_TIMEOUT = 2'b11;

endpackage

// File: rtl/i281_mem_watch.sv
// Data-memory watch: selects one byte from the flattened datamem bus and
// compares it against the watch value. Indices beyond NUM_WORDS never match.
module i281_mem_watch #(
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic [NUM_WORDS*8-1:0]         i_datamem_flat,
  input  logic [$clog2(NUM_WORDS)-1:0]   i_watch_idx,
  input  logic [7:0]                     i_watch_value,
  input  logic                           i_watch_en,
  output logic                           o_watch_hit
);

  // One-hot style scan keeps out-of-range indices from aliasing onto a word
  always_comb begin
    o_watch_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_WORDS; k++) begin
      if (i_watch_en && (32'(i_watch_idx) == k) &&
          (i_datamem_flat[8*k +: 8] == i_watch_value)) begin
        o_watch_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i281_run_sequencer.sv
// Run/reset sequencer for the i281 multicycle CPU. Holds cpu_reset after
// start, inserts one gap cycle, then drives cpu_run freely or per step edge
// until abort, halt, a data-memory watch match or the cycle budget.
// Optional feature: define I281_RUN_SEQ_WATCH_EN to build the watch stop.
module i281_run_sequencer
  import i281_run_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned MAX_CYCLES   = 500,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned NUM_WORDS    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         step_mode,
  input  logic                         step,
  input  logic                         halt,
  input  logic [NUM_WORDS*8-1:0]       datamem_flat,
  input  logic [$clog2(NUM_WORDS)-1:0] watch_idx,
  input  logic [7:0]                   watch_value,
  input  logic                         watch_en,
  output logic                         cpu_reset,
  output logic                         cpu_run,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   stop_code,
  output logic [CNT_W-1:0]             cycle_count
);

  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  seq_state_t         r_state, w_state_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
  logic               r_step_mode, w_step_mode_nxt;
  logic               r_step_q;
  logic               r_cpu_reset, w_cpu_reset_nxt;
  logic               r_cpu_run, w_cpu_run_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [1:0]         r_stop_code, w_stop_nxt;
  logic [CNT_W-1:0]   r_cycle_count, w_cnt_nxt, w_cnt_run;
  logic               w_step_rise;
  logic               w_watch_hit;

`ifdef I281_RUN_SEQ_WATCH_EN
  i281_mem_watch #(
    .NUM_WORDS(NUM_WORDS)
  ) u_mem_watch (
    .i_datamem_flat (datamem_flat),
    .i_watch_idx    (watch_idx),
    .i_watch_value  (watch_value),
    .i_watch_en     (watch_en),
    .o_watch_hit    (w_watch_hit)
  );
`else
  logic w_unused_watch;
  assign w_unused_watch = ^{datamem_flat, watch_idx, watch_value, watch_en};
  assign w_watch_hit    = 1'b0;
`endif

  assign w_step_rise = step & ~r_step_q;

  // Count including the current cycle, so a timeout stops at exactly MAX_CYCLES
  assign w_cnt_run = r_cycle_count + CNT_W'(r_cpu_run);

  // State, counters and all outputs are registered from their next values
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_hold_cnt    <= '0;
      r_step_mode   <= 1'b0;
      r_step_q      <= 1'b0;
      r_cpu_reset   <= 1'b1;
      r_cpu_run     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_stop_code   <= STOP_ABORT;
      r_cycle_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_step_mode   <= w_step_mode_nxt;
      r_step_q      <= step;
      r_cpu_reset   <= w_cpu_reset_nxt;
      r_cpu_run     <= w_cpu_run_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_stop_code   <= w_stop_nxt;
      r_cycle_count <= w_cnt_nxt;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they are
  // registered yet aligned with the state they describe
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold_cnt;
    w_step_mode_nxt = r_step_mode;
    w_stop_nxt      = r_stop_code;
    w_cnt_nxt       = r_cycle_count;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = HOLD_W'(RESET_CYCLES - 1);
          w_cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = ST_GAP;
        else                  w_hold_nxt  = r_hold_cnt - 1'b1;
      end
      ST_GAP: begin
        w_step_mode_nxt = step_mode;
        w_state_nxt     = ST_RUN;
      end
      ST_RUN: begin
        w_cnt_nxt = w_cnt_run;
        if (abort) begin
          w_state_nxt = ST_DONE;
          w_stop_nxt  = STOP_ABORT;
        end else if (halt) begin
          w_state_nxt = ST_DONE;
          w_stop_nxt  = STOP_HALT;
        end else if (w_watch_hit) begin
          w_state_nxt = ST_DONE;
          w_stop_nxt  = STOP_WATCH;
        end else if (w_cnt_run == CNT_W'(MAX_CYCLES)) begin
          w_state_nxt = ST_DONE;
          w_stop_nxt  = STOP_TIMEOUT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_cpu_reset_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HOLD);
    w_busy_nxt      = (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_GAP) ||
                      (w_state_nxt == ST_RUN);
    w_done_nxt      = (w_state_nxt == ST_DONE);
    w_cpu_run_nxt   = (w_state_nxt == ST_RUN) && (!w_step_mode_nxt || w_step_rise);
  end

  assign cpu_reset   = r_cpu_reset;
  assign cpu_run     = r_cpu_run;
  assign busy        = r_busy;
  assign done        = r_done;
  assign stop_code   = r_stop_code;
  assign cycle_count = r_cycle_count;

endmodule
